// File: rtl/sw_host_pkg.sv
// Shared types and constants for the SmithWaterman host agent.
// Holds the FSM state encoding, the trace entry layout and the read-latency range check.
package sw_host_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_GUARD,
      ST_RUN,
      ST_DONE,
      ST_TOUT
   } state_t;

   localparam int RD_LAT_MAX  = 4;
   localparam int TRACE_DEPTH = 8;

   // Trace entry layout for the default widths (q_idx, t_idx, result).
   typedef struct packed {
      logic [7:0]  q_idx;
      logic [7:0]  t_idx;
      logic [15:0] result;
   } trace_entry_t;

   // An out-of-range read latency is clamped to 0..RD_LAT_MAX.
   function automatic int rd_lat_stages(input int lat);
      if (lat < 0) return 0;
      if (lat > RD_LAT_MAX) return RD_LAT_MAX;
      return lat;
   endfunction

endpackage

// File: rtl/sw_host_mem.sv
// Target/query word banks for the host agent: one write port and one read port,
// with an RD_LAT-deep registered read pipeline (0 gives a combinational read).
module sw_host_mem
   import sw_host_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int ADDR_W = 10,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic              wr_sel_t,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              rd_sel_t,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WORD_W-1:0] rd_data
);

   localparam int STAGES = rd_lat_stages(RD_LAT);
   localparam int DEPTH  = 2 ** ADDR_W;

   logic [WORD_W-1:0] bank_t [DEPTH];
   logic [WORD_W-1:0] bank_q [DEPTH];
   logic [WORD_W-1:0] rd_raw;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (wr_sel_t) bank_t[wr_addr] <= wr_data;
         else          bank_q[wr_addr] <= wr_data;
      end
   end

   // Write lands on the edge, so a same-cycle read still sees the old word.
   assign rd_raw = rd_sel_t ? bank_t[rd_addr] : bank_q[rd_addr];

   generate
      if (STAGES == 0) begin : g_comb
         assign rd_data = rd_raw;
      end else begin : g_pipe
         logic [WORD_W-1:0] pipe [STAGES];
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
            end else begin
               pipe[0] <= rd_raw;
               for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
            end
         end
         assign rd_data = pipe[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/sw_host_agent.sv
// Host agent for the SmithWaterman core: banks, start sequencing, completion/timeout and scoreboard.
// Optional trace buffer enabled by defining SW_HOST_TRACE_EN.
//
// state | meaning
// IDLE  | after reset; bank loads accepted
// START | start_o pulse to the core
// GUARD | one cycle while the core raises busy; busy_i ignored
// RUN   | core working; scoreboard active; timeout counter running
// DONE  | core dropped busy; done_o held
// TOUT  | timeout expired with busy still high; timeout_o held
module sw_host_agent
   import sw_host_pkg::*;
#(
   parameter int WORD_W  = 32,
   parameter int ADDR_W  = 10,
   parameter int CALC_W  = 16,
   parameter int TIDX_W  = 8,
   parameter int QIDX_W  = 8,
   parameter int RD_LAT  = 1,
   parameter int TIMEOUT = 50000,
   parameter int ERR_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_en,
   input  logic              load_sel_t,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [WORD_W-1:0] load_data,
   input  logic              start_req,
   output logic              start_o,
   input  logic              busy_i,
   input  logic              sel_t_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic [WORD_W-1:0] data_o,
   input  logic              valid_i,
   input  logic [CALC_W-1:0] result_i,
   input  logic              change_q_i,
   input  logic [TIDX_W-1:0] match_idx_i,
   input  logic [CALC_W-1:0] max_result_i,
   output logic [TIDX_W-1:0] t_idx_o,
   output logic [QIDX_W-1:0] q_idx_o,
   output logic              done_o,
   output logic              timeout_o,
   output logic              err_o,
   output logic [ERR_W-1:0]  err_cnt_o
`ifdef SW_HOST_TRACE_EN
   ,
   input  logic [2:0]                      trace_rd_idx,
   output logic [QIDX_W+TIDX_W+CALC_W-1:0] trace_data_o,
   output logic [3:0]                      trace_cnt_o
`endif
);

   localparam int              CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

   state_t            state, state_nxt;
   logic              accept_start;
   logic [CNT_W-1:0]  cyc_cnt;
   logic [CALC_W-1:0] run_max, eff_max;
   logic [TIDX_W-1:0] run_idx, eff_idx;
   logic              sb_valid, better, mismatch;

   sw_host_mem #(
      .WORD_W (WORD_W),
      .ADDR_W (ADDR_W),
      .RD_LAT (RD_LAT)
   ) u_mem (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (load_en && (state == ST_IDLE)),
      .wr_sel_t (load_sel_t),
      .wr_addr  (load_addr),
      .wr_data  (load_data),
      .rd_sel_t (sel_t_i),
      .rd_addr  (addr_i),
      .rd_data  (data_o)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      accept_start = 1'b0;
      case (state)
         ST_IDLE, ST_DONE, ST_TOUT: begin
            if (start_req) begin
               state_nxt    = ST_START;
               accept_start = 1'b1;
            end
         end
         ST_START: state_nxt = ST_GUARD;
         ST_GUARD: state_nxt = ST_RUN;
         ST_RUN: begin
            // Busy falling takes priority over an expiring counter.
            if (!busy_i)               state_nxt = ST_DONE;
            else if (cyc_cnt == '0)    state_nxt = ST_TOUT;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign start_o = (state == ST_START);

   // Down-counter loaded in GUARD; terminal count on the TIMEOUT-th RUN cycle.
   always_ff @(posedge clk) begin
      if (!rst_n)                                  cyc_cnt <= '0;
      else if (accept_start)                       cyc_cnt <= '0;
      else if (state == ST_GUARD)                  cyc_cnt <= CNT_LOAD;
      else if (state == ST_RUN && cyc_cnt != '0)   cyc_cnt <= cyc_cnt - 1'b1;
   end

   assign sb_valid = (state == ST_RUN) && valid_i;
   assign better   = result_i > run_max;
   assign eff_max  = better ? result_i : run_max;
   assign eff_idx  = better ? t_idx_o  : run_idx;
   assign mismatch = (match_idx_i != eff_idx) || (max_result_i != eff_max);

   always_ff @(posedge clk) begin
      if (!rst_n || accept_start) begin
         done_o    <= 1'b0;
         timeout_o <= 1'b0;
         err_o     <= 1'b0;
         err_cnt_o <= '0;
         t_idx_o   <= '0;
         q_idx_o   <= '0;
         run_max   <= '0;
         run_idx   <= '0;
      end else begin
         if (state == ST_RUN && state_nxt == ST_DONE) done_o    <= 1'b1;
         if (state == ST_RUN && state_nxt == ST_TOUT) timeout_o <= 1'b1;
         if (sb_valid) begin
            if (change_q_i) begin
               if (mismatch) begin
                  err_o <= 1'b1;
                  if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
               end
               t_idx_o <= '0;
               q_idx_o <= q_idx_o + 1'b1;
               run_max <= '0;
               run_idx <= '0;
            end else begin
               t_idx_o <= t_idx_o + 1'b1;
               run_max <= eff_max;
               run_idx <= eff_idx;
            end
         end
      end
   end

`ifdef SW_HOST_TRACE_EN
   localparam int TR_W = QIDX_W + TIDX_W + CALC_W;

   logic [TR_W-1:0] trace_mem [TRACE_DEPTH];
   logic [2:0]      trace_wr_ptr;

   // Circular buffer: the write pointer simply wraps, overwriting the oldest entry.
   always_ff @(posedge clk) begin
      if (!rst_n || state == ST_START) begin
         for (int i = 0; i < TRACE_DEPTH; i++) trace_mem[i] <= '0;
         trace_wr_ptr <= '0;
         trace_cnt_o  <= '0;
      end else if (sb_valid) begin
         trace_mem[trace_wr_ptr] <= {q_idx_o, t_idx_o, result_i};
         trace_wr_ptr            <= trace_wr_ptr + 1'b1;
         if (trace_cnt_o != 4'd8) trace_cnt_o <= trace_cnt_o + 1'b1;
      end
   end

   assign trace_data_o = trace_mem[trace_rd_idx];
`endif

endmodule

// File: tb/tb_sw_host_agent.sv
// Self-checking bench for sw_host_agent: two instances share stimulus, one with a
// short timeout for timeout checks and one with a long timeout for scoreboard runs.
module tb_sw_host_agent;

   localparam int WORD_W = 32, ADDR_W = 10, CALC_W = 16, TIDX_W = 8, QIDX_W = 8;
   localparam int RD_LAT = 2, ERR_W = 8, TO_SHORT = 20, TO_LONG = 1000;
   localparam int TR_W = QIDX_W + TIDX_W + CALC_W;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n, load_en, load_sel_t, start_req, busy_i, sel_t_i, valid_i, change_q_i;
   logic [ADDR_W-1:0] load_addr, addr_i;
   logic [WORD_W-1:0] load_data;
   logic [CALC_W-1:0] result_i, max_result_i;
   logic [TIDX_W-1:0] match_idx_i;

   logic              l_start, l_done, l_tout, l_err;
   logic [WORD_W-1:0] l_data;
   logic [TIDX_W-1:0] l_t_idx;
   logic [QIDX_W-1:0] l_q_idx;
   logic [ERR_W-1:0]  l_err_cnt;
   logic              s_start, s_done, s_tout, s_err;
   logic [WORD_W-1:0] s_data;
   logic [TIDX_W-1:0] s_t_idx;
   logic [QIDX_W-1:0] s_q_idx;
   logic [ERR_W-1:0]  s_err_cnt;
`ifdef SW_HOST_TRACE_EN
   logic [2:0]      tr_idx, s_tr_idx;
   logic [TR_W-1:0] tr_data, s_tr_data;
   logic [3:0]      tr_cnt, s_tr_cnt;
`endif

   int total = 0;
   int bad   = 0;
   logic [WORD_W-1:0] mdl_t [32];
   logic [WORD_W-1:0] mdl_q [32];

   sw_host_agent #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .CALC_W(CALC_W), .TIDX_W(TIDX_W),
      .QIDX_W(QIDX_W), .RD_LAT(RD_LAT), .TIMEOUT(TO_LONG), .ERR_W(ERR_W)) u_dut (
      .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_sel_t(load_sel_t),
      .load_addr(load_addr), .load_data(load_data), .start_req(start_req), .start_o(l_start),
      .busy_i(busy_i), .sel_t_i(sel_t_i), .addr_i(addr_i), .data_o(l_data),
      .valid_i(valid_i), .result_i(result_i), .change_q_i(change_q_i),
      .match_idx_i(match_idx_i), .max_result_i(max_result_i), .t_idx_o(l_t_idx),
      .q_idx_o(l_q_idx), .done_o(l_done), .timeout_o(l_tout), .err_o(l_err),
      .err_cnt_o(l_err_cnt)
`ifdef SW_HOST_TRACE_EN
      , .trace_rd_idx(tr_idx), .trace_data_o(tr_data), .trace_cnt_o(tr_cnt)
`endif
   );

   sw_host_agent #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .CALC_W(CALC_W), .TIDX_W(TIDX_W),
      .QIDX_W(QIDX_W), .RD_LAT(RD_LAT), .TIMEOUT(TO_SHORT), .ERR_W(ERR_W)) u_short (
      .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_sel_t(load_sel_t),
      .load_addr(load_addr), .load_data(load_data), .start_req(start_req), .start_o(s_start),
      .busy_i(busy_i), .sel_t_i(sel_t_i), .addr_i(addr_i), .data_o(s_data),
      .valid_i(valid_i), .result_i(result_i), .change_q_i(change_q_i),
      .match_idx_i(match_idx_i), .max_result_i(max_result_i), .t_idx_o(s_t_idx),
      .q_idx_o(s_q_idx), .done_o(s_done), .timeout_o(s_tout), .err_o(s_err),
      .err_cnt_o(s_err_cnt)
`ifdef SW_HOST_TRACE_EN
      , .trace_rd_idx(s_tr_idx), .trace_data_o(s_tr_data), .trace_cnt_o(s_tr_cnt)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_valid(input logic [CALC_W-1:0] res, input logic chg,
                              input logic [TIDX_W-1:0] midx, input logic [CALC_W-1:0] mx);
      valid_i = 1'b1; result_i = res; change_q_i = chg; match_idx_i = midx; max_result_i = mx;
      step();
      valid_i = 1'b0; change_q_i = 1'b0;
   endtask

   // Start with busy high; returns at the beginning of the first RUN cycle.
   task automatic do_start();
      busy_i = 1'b1; start_req = 1'b1;
      step();
      start_req = 1'b0;
      step();
      step();
   endtask

   task automatic end_run();
      busy_i = 1'b0;
      step();
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; load_en = 0; load_sel_t = 0; load_addr = '0; load_data = '0;
      start_req = 0; busy_i = 0; sel_t_i = 0; addr_i = '0; valid_i = 0; change_q_i = 0;
      result_i = '0; max_result_i = '0; match_idx_i = '0;
`ifdef SW_HOST_TRACE_EN
      tr_idx = '0; s_tr_idx = '0;
`endif
      repeat (3) step();
      @(negedge clk);
      total++;
      if ({l_start, l_done, l_tout, l_err, l_err_cnt, l_t_idx, l_q_idx, l_data} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got start=%b done=%b tout=%b err=%b cnt=%0d t=%0d q=%0d data=%h exp all 0",
                  l_start, l_done, l_tout, l_err, l_err_cnt, l_t_idx, l_q_idx, l_data);
      end
      total++;
      if ({s_done, s_tout} !== 2'b00) begin
         bad++; $display("FAIL reset_short got done=%b tout=%b exp 0", s_done, s_tout);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_mem();
      logic [WORD_W-1:0] hist [40];
      logic [WORD_W-1:0] old9, new9;
      for (int a = 0; a < 32; a++) begin
         mdl_t[a] = $urandom; mdl_q[a] = $urandom;
      end
      mdl_t[5] = 32'hA5A5_0001; mdl_q[5] = 32'h0000_00FF;
      load_en = 1'b1;
      for (int a = 0; a < 32; a++) begin
         load_sel_t = 1'b1; load_addr = ADDR_W'(a); load_data = mdl_t[a]; step();
         load_sel_t = 1'b0; load_data = mdl_q[a]; step();
      end
      load_en = 1'b0;

      sel_t_i = 1'b1; addr_i = 10'd5;
      step(); step();
      @(negedge clk);
      total++;
      if (l_data !== 32'hA5A5_0001) begin bad++; $display("FAIL rd_t5 got=%h exp=a5a50001", l_data); end
      sel_t_i = 1'b0;
      step();
      @(negedge clk);
      total++;
      if (l_data !== 32'hA5A5_0001) begin bad++; $display("FAIL rd_lat_hold got=%h exp=a5a50001", l_data); end
      step();
      @(negedge clk);
      total++;
      if (l_data !== 32'h0000_00FF) begin bad++; $display("FAIL rd_q5 got=%h exp=000000ff", l_data); end

      old9 = mdl_t[9]; new9 = ~old9;
      sel_t_i = 1'b1; addr_i = 10'd9;
      step(); step();
      load_en = 1'b1; load_sel_t = 1'b1; load_addr = 10'd9; load_data = new9;
      step();
      load_en = 1'b0; mdl_t[9] = new9;
      step();
      @(negedge clk);
      total++;
      if (l_data !== old9) begin bad++; $display("FAIL rd_during_wr got=%h exp=%h", l_data, old9); end
      step();
      @(negedge clk);
      total++;
      if (l_data !== new9) begin bad++; $display("FAIL rd_after_wr got=%h exp=%h", l_data, new9); end

      for (int i = 0; i < 40; i++) begin
         sel_t_i = 1'($urandom_range(0, 1));
         addr_i  = ADDR_W'($urandom_range(0, 31));
         hist[i] = sel_t_i ? mdl_t[addr_i[4:0]] : mdl_q[addr_i[4:0]];
         step();
         @(negedge clk);
         if (i >= 1) begin
            total++;
            if (l_data !== hist[i-1]) begin
               bad++; $display("FAIL rd_random[%0d] got=%h exp=%h", i, l_data, hist[i-1]);
            end
         end
      end
   endtask

   task automatic test_start_done();
      busy_i = 1'b0;
      start_req = 1'b1;
      step();
      start_req = 1'b0;
      @(negedge clk);
      total++;
      if ({l_start, l_done} !== 2'b10) begin bad++; $display("FAIL start_pulse got start=%b done=%b exp 1/0", l_start, l_done); end
      step();
      @(negedge clk);
      total++;
      if ({l_start, l_done} !== 2'b00) begin bad++; $display("FAIL guard_cycle got start=%b done=%b exp 0/0", l_start, l_done); end
      step();
      @(negedge clk);
      total++;
      if (l_done !== 1'b0) begin bad++; $display("FAIL done_early got=%b exp=0", l_done); end
      step();
      @(negedge clk);
      total++;
      if ({l_done, l_tout} !== 2'b10) begin bad++; $display("FAIL done_set got done=%b tout=%b exp 1/0", l_done, l_tout); end
   endtask

   task automatic test_sb_directed();
      do_start();
      @(negedge clk);
      total++;
      if ({l_done, l_q_idx, l_t_idx} !== '0) begin bad++; $display("FAIL start_clears got done=%b q=%0d t=%0d", l_done, l_q_idx, l_t_idx); end
      drive_valid(16'd3, 1'b0, 8'd0, 16'd0);
      drive_valid(16'd9, 1'b0, 8'd0, 16'd0);
      drive_valid(16'd9, 1'b0, 8'd0, 16'd0);
      drive_valid(16'd4, 1'b1, 8'd1, 16'd9);
      @(negedge clk);
      total++;
      if ({l_err, l_q_idx, l_t_idx} !== {1'b0, 8'd1, 8'd0}) begin
         bad++; $display("FAIL sb_match got err=%b q=%0d t=%0d exp 0/1/0", l_err, l_q_idx, l_t_idx);
      end
      drive_valid(16'd3, 1'b0, 8'd0, 16'd0);
      drive_valid(16'd9, 1'b0, 8'd0, 16'd0);
      drive_valid(16'd9, 1'b0, 8'd0, 16'd0);
      drive_valid(16'd4, 1'b1, 8'd2, 16'd9);
      @(negedge clk);
      total++;
      if ({l_err, l_err_cnt, l_q_idx} !== {1'b1, 8'd1, 8'd2}) begin
         bad++; $display("FAIL sb_tie_idx got err=%b cnt=%0d q=%0d exp 1/1/2", l_err, l_err_cnt, l_q_idx);
      end
      end_run();
   endtask

   task automatic test_sb_random();
      int vals[$];
      int n, best, bidx, kind, exp_q, exp_cnt;
      logic [TIDX_W-1:0] midx;
      logic [CALC_W-1:0] mx;
      logic [CALC_W-1:0] r;
      exp_q = 0; exp_cnt = 0;
      do_start();
      load_en = 1'b1; load_sel_t = 1'b1; load_addr = 10'd20; load_data = ~mdl_t[20];
      step();
      load_en = 1'b0;
      for (int q = 0; q < 25; q++) begin
         vals.delete();
         n = $urandom_range(1, 6);
         for (int j = 0; j < n; j++) begin
            if ($urandom_range(0, 3) == 0) step();
            r = CALC_W'($urandom_range(0, 15));
            vals.push_back(int'(r));
            if (j < n - 1) begin
               drive_valid(r, 1'b0, 8'd0, 16'd0);
               @(negedge clk);
               total++;
               if (l_t_idx !== TIDX_W'(j + 1)) begin
                  bad++; $display("FAIL sb_t_idx q=%0d got=%0d exp=%0d", q, l_t_idx, j + 1);
               end
            end else begin
               best = 0;
               foreach (vals[k]) if (vals[k] > best) best = vals[k];
               bidx = 0;
               for (int k = vals.size() - 1; k >= 0; k--) if (vals[k] == best) bidx = k;
               kind = $urandom_range(0, 2);
               midx = TIDX_W'(bidx + (kind == 1 ? 1 : 0));
               mx   = CALC_W'(best + (kind == 2 ? 1 : 0));
               drive_valid(r, 1'b1, midx, mx);
               exp_q++;
               if (kind != 0) exp_cnt++;
               @(negedge clk);
               total++;
               if ({l_q_idx, l_t_idx, l_err_cnt, l_err} !==
                   {QIDX_W'(exp_q), TIDX_W'(0), ERR_W'(exp_cnt), exp_cnt != 0}) begin
                  bad++;
                  $display("FAIL sb_query q=%0d got q=%0d t=%0d cnt=%0d err=%b exp q=%0d t=0 cnt=%0d",
                           q, l_q_idx, l_t_idx, l_err_cnt, l_err, exp_q, exp_cnt);
               end
            end
         end
      end
      end_run();
      @(negedge clk);
      total++;
      if (l_done !== 1'b1) begin bad++; $display("FAIL sb_run_done got=%b exp=1", l_done); end
   endtask

   task automatic test_timeout();
      do_start();
      for (int k = 1; k <= TO_SHORT; k++) begin
         @(negedge clk);
         total++;
         if (s_tout !== 1'b0) begin bad++; $display("FAIL tout_early k=%0d got=%b exp=0", k, s_tout); end
         if (k == 6) begin
            total++;
            if ({l_start, s_start} !== 2'b00) begin
               bad++; $display("FAIL start_in_run got=%b%b exp=00", l_start, s_start);
            end
         end
         start_req = (k == 5);
         step();
      end
      start_req = 1'b0;
      @(negedge clk);
      total++;
      if ({s_tout, s_done} !== 2'b10) begin bad++; $display("FAIL tout_set got tout=%b done=%b exp 1/0", s_tout, s_done); end
      end_run();

      do_start();
      @(negedge clk);
      total++;
      if (s_tout !== 1'b0) begin bad++; $display("FAIL tout_cleared got=%b exp=0", s_tout); end
      repeat (TO_SHORT - 1) step();
      busy_i = 1'b0;
      step();
      @(negedge clk);
      total++;
      if ({s_done, s_tout} !== 2'b10) begin bad++; $display("FAIL tout_vs_done got done=%b tout=%b exp 1/0", s_done, s_tout); end
   endtask

   task automatic test_err_saturate();
      logic [CALC_W-1:0] r;
      int exp_cnt;
      do_start();
      for (int i = 0; i < 300; i++) begin
         r = CALC_W'($urandom_range(0, 100));
         drive_valid(r, 1'b1, 8'd0, r + 16'd1);
         exp_cnt = (i + 1 > 255) ? 255 : i + 1;
         @(negedge clk);
         total++;
         if (l_err_cnt !== ERR_W'(exp_cnt)) begin
            bad++; $display("FAIL err_cnt[%0d] got=%0d exp=%0d", i, l_err_cnt, exp_cnt);
         end
      end
      total++;
      if ({l_err, l_q_idx} !== {1'b1, QIDX_W'(300 % 256)}) begin
         bad++; $display("FAIL err_sat_state got err=%b q=%0d exp 1/%0d", l_err, l_q_idx, 300 % 256);
      end
      end_run();
   endtask

   task automatic test_reset_midrun();
      do_start();
      drive_valid(16'd7, 1'b1, 8'd3, 16'd7);
      drive_valid(16'd5, 1'b0, 8'd0, 16'd0);
      start_req = 1'b1;
      rst_n = 1'b0;
      step();
      start_req = 1'b0;
      @(negedge clk);
      total++;
      if ({l_start, l_done, l_tout, l_err, l_err_cnt, l_t_idx, l_q_idx, l_data} !== '0) begin
         bad++;
         $display("FAIL midrun_reset got start=%b done=%b tout=%b err=%b cnt=%0d t=%0d q=%0d data=%h exp all 0",
                  l_start, l_done, l_tout, l_err, l_err_cnt, l_t_idx, l_q_idx, l_data);
      end
      rst_n = 1'b1;
      sel_t_i = 1'b1; addr_i = 10'd20;
      step(); step();
      @(negedge clk);
      total++;
      if (l_data !== mdl_t[20]) begin bad++; $display("FAIL load_in_run_ignored got=%h exp=%h", l_data, mdl_t[20]); end
      busy_i = 1'b0; start_req = 1'b1;
      step();
      start_req = 1'b0;
      @(negedge clk);
      total++;
      if (l_start !== 1'b1) begin bad++; $display("FAIL restart_pulse got=%b exp=1", l_start); end
      step(); step(); step();
      @(negedge clk);
      total++;
      if ({l_done, l_err} !== 2'b10) begin bad++; $display("FAIL restart_done got done=%b err=%b exp 1/0", l_done, l_err); end
   endtask

`ifdef SW_HOST_TRACE_EN
   task automatic test_trace();
      do_start();
      for (int i = 1; i <= 10; i++) drive_valid(CALC_W'(i), 1'b0, 8'd0, 16'd0);
      @(negedge clk);
      total++;
      if (tr_cnt !== 4'd8) begin bad++; $display("FAIL trace_cnt got=%0d exp=8", tr_cnt); end
      tr_idx = 3'd2;
      #1;
      total++;
      if (tr_data !== {8'd0, 8'd2, 16'd3}) begin bad++; $display("FAIL trace_oldest got=%h exp=%h", tr_data, {8'd0, 8'd2, 16'd3}); end
      tr_idx = 3'd1;
      #1;
      total++;
      if (tr_data !== {8'd0, 8'd9, 16'd10}) begin bad++; $display("FAIL trace_newest got=%h exp=%h", tr_data, {8'd0, 8'd9, 16'd10}); end
      end_run();
   endtask
`endif

   initial begin
      test_reset();
      test_mem();
      test_start_done();
      test_sb_directed();
      test_sb_random();
      test_timeout();
      test_err_saturate();
      test_reset_midrun();
`ifdef SW_HOST_TRACE_EN
      test_trace();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
